// File: rtl/qpu_exu_wbck_ctrl.sv
// QPU execution-unit write-back controller: shares the CRF write port
// between ALU and long-pipe results and sequences MCU measurement returns.
module qpu_exu_wbck_ctrl #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int QUBIT_NUM  = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 alu_cwbck_i_valid,
    output logic                 alu_cwbck_i_ready,
    input  logic [XLEN-1:0]      alu_cwbck_i_data,
    input  logic [RFIDX_W-1:0]   alu_cwbck_i_rdidx,

    input  logic                 lsu_rsp_valid,
    output logic                 lsu_rsp_ready,
    input  logic [XLEN-1:0]      lsu_rsp_rdata,

    input  logic [RFIDX_W-1:0]   oitf_ret_rdidx,
    input  logic                 oitf_ret_rdwen,
    input  logic                 oitf_empty,
    output logic                 oitf_ret_ena,

    input  logic                 mcu_rsp_valid,
    output logic                 mcu_rsp_ready,
    input  logic [QUBIT_NUM-1:0] mcu_rsp_data,

    input  logic [QUBIT_NUM-1:0] moitf_ret_mf,
    input  logic                 moitf_empty,
    output logic                 moitf_ret_ena,

    output logic                 crf_wbck_ena,
    output logic [RFIDX_W-1:0]   crf_wbck_idx,
    output logic [XLEN-1:0]      crf_wbck_data,

    output logic                 mrf_wbck_ena,
    output logic [QUBIT_NUM-1:0] mrf_wbck_mask,
    output logic [QUBIT_NUM-1:0] mrf_wbck_data,

    output logic                 wbck_err
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic                 r_lp_vld;
    logic [XLEN-1:0]      r_lp_data;
    logic [RFIDX_W-1:0]   r_lp_idx;
    logic                 r_lp_wen;
    logic [CNT_W-1:0]     r_starve;
    logic                 r_m_pend;
    logic [QUBIT_NUM-1:0] r_m_mask;
    logic [QUBIT_NUM-1:0] r_m_data;
    logic                 r_err;

    logic                 w_lp_req;
    logic                 w_alu_req;
    logic                 w_force;
    logic                 w_alu_grant;
    logic                 w_lp_grant;
    logic                 w_lp_drain;
    logic                 w_lsu_ready;
    logic                 w_lsu_acc;
    logic                 w_mcu_ready;
    logic                 w_mcu_acc;
    logic                 w_err_set;
    logic [RFIDX_W-1:0]   w_crf_idx;
    logic [XLEN-1:0]      w_crf_data;

    // Readies are gated by rst_n so every output is quiet while in reset.
    assign w_lp_req    = r_lp_vld & r_lp_wen;
    assign w_alu_req   = rst_n & alu_cwbck_i_valid;
    assign w_force     = (r_starve == CNT_MAX);
    assign w_alu_grant = w_alu_req & (~w_lp_req | w_force);
    assign w_lp_grant  = w_lp_req & ~w_alu_grant;
    assign w_lp_drain  = r_lp_vld & (~r_lp_wen | w_lp_grant);
    assign w_lsu_ready = rst_n & ~oitf_empty & (~r_lp_vld | w_lp_drain);
    assign w_lsu_acc   = lsu_rsp_valid & w_lsu_ready;
    assign w_mcu_ready = rst_n & ~moitf_empty & ~r_m_pend;
    assign w_mcu_acc   = mcu_rsp_valid & w_mcu_ready;
    assign w_err_set   = (lsu_rsp_valid & oitf_empty)
                       | (mcu_rsp_valid & moitf_empty);

    always_comb begin
        w_crf_idx  = '0;
        w_crf_data = '0;
        unique case (1'b1)
            w_alu_grant: begin
                w_crf_idx  = alu_cwbck_i_rdidx;
                w_crf_data = alu_cwbck_i_data;
            end
            w_lp_grant: begin
                w_crf_idx  = r_lp_idx;
                w_crf_data = r_lp_data;
            end
            default: begin
                w_crf_idx  = '0;
                w_crf_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lp_vld  <= 1'b0;
            r_lp_data <= '0;
            r_lp_idx  <= '0;
            r_lp_wen  <= 1'b0;
        end else if (w_lsu_acc) begin
            r_lp_vld  <= 1'b1;
            r_lp_data <= lsu_rsp_rdata;
            r_lp_idx  <= oitf_ret_rdidx;
            r_lp_wen  <= oitf_ret_rdwen;
        end else if (w_lp_drain) begin
            r_lp_vld  <= 1'b0;
        end
    end

    // Counts ALU cycles lost to the long pipe; saturates at the force level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_alu_grant) begin
            r_starve <= '0;
        end else if (w_alu_req && (r_starve != CNT_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_pend <= 1'b0;
            r_m_mask <= '0;
            r_m_data <= '0;
        end else if (w_mcu_acc) begin
            r_m_pend <= 1'b1;
            r_m_mask <= moitf_ret_mf;
            r_m_data <= mcu_rsp_data & moitf_ret_mf;
        end else if (r_m_pend) begin
            r_m_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign alu_cwbck_i_ready = w_alu_grant;
    assign lsu_rsp_ready     = w_lsu_ready;
    assign oitf_ret_ena      = w_lp_drain;
    assign mcu_rsp_ready     = w_mcu_ready;
    assign moitf_ret_ena     = r_m_pend;

    assign crf_wbck_ena      = w_alu_grant | w_lp_grant;
    assign crf_wbck_idx      = w_crf_idx;
    assign crf_wbck_data     = w_crf_data;

    assign mrf_wbck_ena      = r_m_pend;
    assign mrf_wbck_mask     = r_m_pend ? r_m_mask : '0;
    assign mrf_wbck_data     = r_m_pend ? r_m_data : '0;

    assign wbck_err          = r_err;

endmodule

// File: tb/tb_qpu_exu_wbck_ctrl.sv
// Bench for qpu_exu_wbck_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the write-back rules.
module tb_qpu_exu_wbck_ctrl;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int QN   = 8;
    localparam int SMAX = 3;

    logic          clk;
    logic          rst_n;
    logic          alu_v;
    logic          alu_r;
    logic [31:0]   alu_d;
    logic [4:0]    alu_i;
    logic          lsu_v;
    logic          lsu_r;
    logic [31:0]   lsu_d;
    logic [4:0]    o_idx;
    logic          o_wen;
    logic          o_empty;
    logic          o_ret;
    logic          mcu_v;
    logic          mcu_r;
    logic [7:0]    mcu_d;
    logic [7:0]    mo_mf;
    logic          mo_empty;
    logic          mo_ret;
    logic          crf_en;
    logic [4:0]    crf_i;
    logic [31:0]   crf_d;
    logic          mrf_en;
    logic [7:0]    mrf_m;
    logic [7:0]    mrf_d;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    qpu_exu_wbck_ctrl #(
        .XLEN(XLEN), .RFIDX_W(RW), .QUBIT_NUM(QN), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_cwbck_i_valid(alu_v), .alu_cwbck_i_ready(alu_r),
        .alu_cwbck_i_data(alu_d), .alu_cwbck_i_rdidx(alu_i),
        .lsu_rsp_valid(lsu_v), .lsu_rsp_ready(lsu_r),
        .lsu_rsp_rdata(lsu_d),
        .oitf_ret_rdidx(o_idx), .oitf_ret_rdwen(o_wen),
        .oitf_empty(o_empty), .oitf_ret_ena(o_ret),
        .mcu_rsp_valid(mcu_v), .mcu_rsp_ready(mcu_r),
        .mcu_rsp_data(mcu_d),
        .moitf_ret_mf(mo_mf), .moitf_empty(mo_empty),
        .moitf_ret_ena(mo_ret),
        .crf_wbck_ena(crf_en), .crf_wbck_idx(crf_i),
        .crf_wbck_data(crf_d),
        .mrf_wbck_ena(mrf_en), .mrf_wbck_mask(mrf_m),
        .mrf_wbck_data(mrf_d),
        .wbck_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: one held long-pipe result, a starvation tally,
    // an optional pending measurement, and the sticky error.
    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        bit          wen;
    } lp_t;

    lp_t         held[$];
    int          starve;
    bit          m_pend;
    logic [7:0]  m_mask;
    logic [7:0]  m_data;
    bit          m_err;
    int          alu_wins_seen;
    int          lp_wins_seen;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held.delete();
        starve = 0;
        m_pend = 0;
        m_mask = '0;
        m_data = '0;
        m_err  = 0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        bit          lp_wants, alu_wins, lp_wins, retire, lsu_ok, mcu_ok;
        logic [4:0]  e_idx;
        logic [31:0] e_dat;
        lp_t         e;
        #2;
        if (!rst_n) begin
            lp_wants = 0; alu_wins = 0; lp_wins = 0;
            retire = 0; lsu_ok = 0; mcu_ok = 0;
        end else begin
            lp_wants = (held.size() == 1) && held[0].wen;
            alu_wins = alu_v && (!lp_wants || starve >= SMAX);
            lp_wins  = lp_wants && !alu_wins;
            retire   = (held.size() == 1) && (!held[0].wen || lp_wins);
            lsu_ok   = !o_empty && (held.size() == 0 || retire);
            mcu_ok   = !mo_empty && !m_pend;
        end
        e_idx = '0;
        e_dat = '0;
        if (alu_wins) begin
            e_idx = alu_i;
            e_dat = alu_d;
        end else if (lp_wins) begin
            e_idx = held[0].idx;
            e_dat = held[0].data;
        end
        check("alu_ready", alu_r, alu_wins);
        check("lsu_ready", lsu_r, lsu_ok);
        check("oitf_ret", o_ret, retire);
        check("crf_ena", crf_en, alu_wins || lp_wins);
        check("crf_idx", crf_i, e_idx);
        check("crf_data", crf_d, e_dat);
        check("mcu_ready", mcu_r, mcu_ok);
        check("mrf_ena", mrf_en, rst_n && m_pend);
        check("mrf_mask", mrf_m, (rst_n && m_pend) ? m_mask : 8'h0);
        check("mrf_data", mrf_d, (rst_n && m_pend) ? m_data : 8'h0);
        check("moitf_ret", mo_ret, rst_n && m_pend);
        check("wbck_err", err, rst_n && m_err);
        if (alu_wins) alu_wins_seen++;
        if (lp_wins)  lp_wins_seen++;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (alu_wins) starve = 0;
            else if (alu_v && starve < SMAX) starve++;
            if (retire) void'(held.pop_front());
            if (lsu_v && lsu_ok) begin
                e.data = lsu_d;
                e.idx  = o_idx;
                e.wen  = o_wen;
                held.push_back(e);
            end
            if (m_pend) m_pend = 0;
            else if (mcu_v && mcu_ok) begin
                m_pend = 1;
                m_mask = mo_mf;
                m_data = mcu_d & mo_mf;
            end
            if ((lsu_v && o_empty) || (mcu_v && mo_empty)) m_err = 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        alu_v = 0; alu_d = '0; alu_i = '0;
        lsu_v = 0; lsu_d = '0;
        o_idx = '0; o_wen = 0; o_empty = 0;
        mcu_v = 0; mcu_d = '0; mo_mf = '0; mo_empty = 0;
    endtask

    task automatic rand_inputs();
        alu_v    = ($urandom_range(0, 1) == 1);
        alu_d    = $urandom;
        alu_i    = 5'($urandom);
        lsu_v    = ($urandom_range(0, 2) != 0);
        lsu_d    = $urandom;
        o_idx    = 5'($urandom);
        o_wen    = ($urandom_range(0, 3) != 0);
        o_empty  = ($urandom_range(0, 15) == 0);
        mcu_v    = ($urandom_range(0, 1) == 1);
        mcu_d    = 8'($urandom);
        mo_mf    = 8'($urandom);
        mo_empty = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        model_reset();
        alu_wins_seen = 0;
        lp_wins_seen  = 0;

        // Reset held with every requester valid.
        rst_n = 0;
        idle_inputs();
        alu_v = 1; lsu_v = 1; mcu_v = 1;
        o_wen = 1; mo_mf = 8'hFF;
        cyc();
        cyc();
        #1;
        check("rst_alu_ready", alu_r, 1'b0);
        check("rst_lsu_ready", lsu_r, 1'b0);
        rst_n = 1;
        idle_inputs();
        repeat (3) cyc();
        check("post_rst_oitf_ret", o_ret, 1'b0);

        // Long-pipe single result.
        o_idx = 5'd5; o_wen = 1; lsu_v = 1; lsu_d = 32'hDEAD_BEEF;
        cyc();
        lsu_v = 0;
        #1;
        check("lp_ena", crf_en, 1'b1);
        check("lp_idx", crf_i, 5'd5);
        check("lp_data", crf_d, 32'hDEAD_BEEF);
        check("lp_oitf_ret", o_ret, 1'b1);
        cyc();
        check("lp_oitf_pulse", o_ret, 1'b0);

        // Contention: both continuously valid.
        alu_v = 1; alu_i = 5'd9; alu_d = 32'h0000_0A1A;
        lsu_v = 1; o_wen = 1; o_idx = 5'd3;
        alu_wins_seen = 0;
        lp_wins_seen  = 0;
        for (int i = 0; i < 17; i++) begin
            lsu_d = 32'h1000 + i;
            cyc();
        end
        // First cycle goes to the ALU (pipe empty), then 3:1 lp:alu.
        check("cont_alu_grants", alu_wins_seen, 5);
        check("cont_lp_grants", lp_wins_seen, 12);
        alu_v = 0; lsu_v = 0;
        repeat (3) cyc();

        // Store retire alongside an ALU write.
        o_wen = 0; lsu_v = 1; lsu_d = 32'h5555;
        cyc();
        lsu_v = 0; alu_v = 1; alu_i = 5'd7; alu_d = 32'h12;
        #1;
        check("st_oitf_ret", o_ret, 1'b1);
        check("st_crf_idx", crf_i, 5'd7);
        check("st_crf_data", crf_d, 32'h12);
        cyc();
        alu_v = 0;
        cyc();

        // Measurement return.
        mo_mf = 8'b0000_0110; mcu_d = 8'b1111_1010; mcu_v = 1;
        cyc();
        #1;
        check("m_mask", mrf_m, 8'h06);
        check("m_data", mrf_d, 8'h02);
        check("m_ret", mo_ret, 1'b1);
        check("m_busy_ready", mcu_r, 1'b0);
        repeat (4) cyc();
        mcu_v = 0;
        cyc();

        // Response with an empty OITF.
        o_empty = 1; lsu_v = 1;
        #1;
        check("err_lsu_ready", lsu_r, 1'b0);
        cyc();
        lsu_v = 0; o_empty = 0;
        #1;
        check("err_set", err, 1'b1);
        repeat (5) cyc();
        check("err_sticky", err, 1'b1);
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
        check("err_cleared", err, 1'b0);

        // Random traffic with occasional mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 99) != 0);
            cyc();
        end
        rst_n = 1;
        idle_inputs();
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qpu_exu_wbck_ctrl.md
Name: qpu_exu_wbck_ctrl

Overview:
Write-back controller for the QPU execution unit. It shares the single classical register file (CRF) write port between the short-pipe ALU write-back and long-pipe (LSU) responses, and retires OITF entries when their long-pipe result lands. It also sequences measurement-result returns from the MCU into the measurement register file (MRF) and retires the corresponding measurement-OITF (MOITF) entry. It sits between the ALU / LSU / MCU response side and the CRF / MRF / OITF.

Parameters:
XLEN, 32, classical data width
RFIDX_W, 5, CRF index width
QUBIT_NUM, 8, number of qubits, equal to the MRF width
STARVE_MAX, 3, consecutive ALU stall cycles that force an ALU grant

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
alu_cwbck_i_valid  input  1  ALU write-back valid
alu_cwbck_i_ready  output  1  ALU write-back ready
alu_cwbck_i_data  input  XLEN  ALU result
alu_cwbck_i_rdidx  input  RFIDX_W  ALU destination index
lsu_rsp_valid  input  1  long-pipe response valid
lsu_rsp_ready  output  1  long-pipe response ready
lsu_rsp_rdata  input  XLEN  long-pipe read data
oitf_ret_rdidx  input  RFIDX_W  destination index of the OITF head entry
oitf_ret_rdwen  input  1  OITF head entry writes the CRF
oitf_empty  input  1  OITF empty
oitf_ret_ena  output  1  pop the OITF head
mcu_rsp_valid  input  1  measurement result valid
mcu_rsp_ready  output  1  measurement result ready
mcu_rsp_data  input  QUBIT_NUM  measured qubit values
moitf_ret_mf  input  QUBIT_NUM  qubit list of the MOITF head entry
moitf_empty  input  1  MOITF empty
moitf_ret_ena  output  1  pop the MOITF head
crf_wbck_ena  output  1  CRF write enable
crf_wbck_idx  output  RFIDX_W  CRF write index
crf_wbck_data  output  XLEN  CRF write data
mrf_wbck_ena  output  1  MRF write enable
mrf_wbck_mask  output  QUBIT_NUM  MRF per-bit write mask
mrf_wbck_data  output  QUBIT_NUM  MRF write data
wbck_err  output  1  sticky error flag

Behaviour:
Clock and reset
- Single clock. Reset is asynchronous and active-low.
- During reset: holding register invalid, starvation counter 0, measurement pending flag 0, wbck_err 0.
- All outputs are 0 in reset, including every ready output.

Long-pipe path
- A 1-entry holding register (lp_vld, lp_data, lp_idx, lp_wen) captures the response.
- lsu_rsp_ready = ~oitf_empty & (~lp_vld | lp_drain).
- Accept condition: lsu_rsp_valid & lsu_rsp_ready. On accept, latch rdata plus oitf_ret_rdidx and oitf_ret_rdwen at that edge.
- lp_drain = lp_vld & (~lp_wen | lp_grant).
- oitf_ret_ena = lp_drain, a single-cycle pulse.
- Latency: accept at edge N -> oitf_ret_ena and the CRF write occur in cycle N+1 at the earliest.
- Back-to-back: accept while draining is allowed, giving 1 result/cycle throughput.
- lsu_rsp_valid while oitf_empty: response not accepted (ready=0); wbck_err set next cycle and held until reset.

CRF arbitration (single write port, combinational mux)
- Requesters: lp_req = lp_vld & lp_wen; alu_req = alu_cwbck_i_valid.
- Default: lp_req wins (older instruction).
- Starvation counter:
  - Increments each cycle with alu_req & ~alu_grant.
  - Saturates at STARVE_MAX.
  - Clears on alu_grant.
- When counter == STARVE_MAX and alu_req: ALU wins that cycle; long-pipe holds.
- alu_cwbck_i_ready = alu_grant = alu_req & (~lp_req | force).
- lp_grant = lp_req & ~alu_grant.
- crf_wbck_ena = alu_grant | lp_grant; idx and data come from the granted source; idx/data are 0 when ena=0.
- Long-pipe entry with rdwen=0 (store) drains without using the port; ALU may be granted in the same cycle.

Measurement path
- mcu_rsp_ready = ~moitf_empty & ~m_pend.
- Accept: register mask = moitf_ret_mf and data = mcu_rsp_data & moitf_ret_mf; set m_pend.
- Next cycle: mrf_wbck_ena=1, mrf_wbck_mask and mrf_wbck_data driven, moitf_ret_ena=1; clear m_pend.
- Throughput is 1 result per 2 cycles.
- mcu_rsp_valid while moitf_empty: not accepted; wbck_err set.
- The measurement path is independent of CRF arbitration; both paths may write in the same cycle.

Reset mid-operation
- Pending long-pipe and measurement results are discarded.
- No OITF or MOITF pop is issued after reset deasserts.

Test Plan:
- Reset: hold rst_n=0 with all inputs valid -> every output 0; release -> oitf_ret_ena stays 0 until a response is accepted.
- Long-pipe only: oitf holds rdidx=5, rdwen=1; lsu_rsp_rdata=0xDEAD_BEEF accepted cycle N -> cycle N+1 crf_wbck_ena=1, idx=5, data=0xDEADBEEF, oitf_ret_ena=1 for exactly 1 cycle.
- Contention/starvation (STARVE_MAX=3): lsu and alu continuously valid -> long-pipe granted 3 cycles, ALU granted on the 4th, counter returns to 0, pattern repeats; no result lost or duplicated.
- Store retire: rdwen=0 entry with alu_cwbck_i_valid=1, rdidx=7, data=0x12 -> same cycle: oitf_ret_ena=1, crf_wbck_idx=7, data=0x12.
- Measurement: moitf_ret_mf=8'b0000_0110, mcu_rsp_data=8'b1111_1010 -> next cycle mrf_wbck_mask=0x06, mrf_wbck_data=0x02, moitf_ret_ena=1; mcu_rsp_ready=0 during the pending cycle.
- Error: lsu_rsp_valid=1 with oitf_empty=1 -> lsu_rsp_ready=0, wbck_err=1 next cycle and stays 1 until rst_n=0.
